pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline stage register for the MIPS pipeline: the next-generation replacement for the fixed EX/MEM latch. It carries a control field and a data payload of configurable width across one stage boundary with a valid/ready handshake, a 2-entry skid buffer, and a synchronous flush. Control bits are forced to zero whenever no valid instruction is presented, so downstream stages see a NOP bubble. The same block is instantiated at IF/ID, ID/EX, EX/MEM and MEM/WB.

---
 rtl/mips_pipe_pkg.sv | 25 ++
 rtl/pipe_stage_reg_if.sv | 27 ++
 rtl/pipe_reg_stats.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 135 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the elastic MIPS pipeline stage registers:
// per-boundary default widths, EX/MEM control-bit indices and the slot-occupancy state type.
package mips_pipe_pkg;

  localparam int unsigned IDEX_CTRL_W  = 32'd9;
  localparam int unsigned IDEX_DATA_W  = 32'd138;
  localparam int unsigned EXMEM_CTRL_W = 32'd5;
  localparam int unsigned EXMEM_DATA_W = 32'd102;
  localparam int unsigned MEMWB_CTRL_W = 32'd2;
  localparam int unsigned MEMWB_DATA_W = 32'd69;

  // EX/MEM control field layout, MSB first: Branch, MemRead, MemWrite, RegWrite, MemtoReg
  localparam int unsigned EXMEM_BRANCH   = 32'd4;
  localparam int unsigned EXMEM_MEMREAD  = 32'd3;
  localparam int unsigned EXMEM_MEMWRITE = 32'd2;
  localparam int unsigned EXMEM_REGWRITE = 32'd1;
  localparam int unsigned EXMEM_MEMTOREG = 32'd0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream valid-ready bundle of one pipeline stage register.
// master = environment side driving the stage, slave = the stage itself.
interface pipe_stage_reg_if
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W
);
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data
  );

  modport slave (
    input  in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data
  );
endinterface

// File: rtl/pipe_reg_stats.sv
// Saturating stall/bubble cycle counters for a pipeline stage register.
// Cleared only by the asynchronous reset.
module pipe_reg_stats #(
  parameter int unsigned STAT_W = 32'd16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_inc_i,
  input  logic              bubble_inc_i,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] bubble_cnt_o
);
  logic [STAT_W-1:0] stall_q, stall_d;
  logic [STAT_W-1:0] bubble_q, bubble_d;

  // next counts, holding at all-ones
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (stall_inc_i && (stall_q != {STAT_W{1'b1}})) begin
      stall_d = stall_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_d = stall_q;
    end
    if (bubble_inc_i && (bubble_q != {STAT_W{1'b1}})) begin
      bubble_d = bubble_q + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      bubble_d = bubble_q;
    end
  end

  // counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q  <= {STAT_W{1'b0}};
      bubble_q <= {STAT_W{1'b0}};
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  assign stall_cnt_o  = stall_q;
  assign bubble_cnt_o = bubble_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register: main slot + skid slot, registered in_ready,
// control zeroed on bubbles, synchronous flush. Optional counters under PIPE_REG_STATS_EN.
module pipe_stage_reg
  import mips_pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = EXMEM_CTRL_W,
  parameter int unsigned DATA_W = EXMEM_DATA_W
`ifdef PIPE_REG_STATS_EN
  , parameter int unsigned STAT_W = 32'd16
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  pipe_stage_reg_if.slave   bus
`ifdef PIPE_REG_STATS_EN
  , output logic [STAT_W-1:0] stall_cnt,
  output logic [STAT_W-1:0] bubble_cnt
`endif
);
  pipe_state_e       st_q, st_d;
  logic              main_vld_q, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic              in_ready_q, in_ready_d;
  logic              in_fire_s, out_fire_s;

  assign in_fire_s  = bus.in_valid & in_ready_q;
  assign out_fire_s = main_vld_q & bus.out_ready;

  // slot occupancy and data movement; main_ctrl is kept zero whenever main is empty
  always_comb begin
    st_d        = st_q;
    main_vld_d  = main_vld_q;
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    in_ready_d  = in_ready_q;
    if (flush) begin
      st_d        = ST_EMPTY;
      main_vld_d  = 1'b0;
      main_ctrl_d = {CTRL_W{1'b0}};
      in_ready_d  = 1'b1;
    end else begin
      case (st_q)
        ST_EMPTY: begin
          in_ready_d = 1'b1;
          if (in_fire_s) begin
            st_d        = ST_ONE;
            main_vld_d  = 1'b1;
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else begin
            st_d = ST_EMPTY;
          end
        end
        ST_ONE: begin
          in_ready_d = 1'b1;
          if (in_fire_s && out_fire_s) begin
            main_ctrl_d = bus.in_ctrl;
            main_data_d = bus.in_data;
          end else if (in_fire_s) begin
            st_d        = ST_TWO;
            skid_ctrl_d = bus.in_ctrl;
            skid_data_d = bus.in_data;
            in_ready_d  = 1'b0;
          end else if (out_fire_s) begin
            st_d        = ST_EMPTY;
            main_vld_d  = 1'b0;
            main_ctrl_d = {CTRL_W{1'b0}};
          end else begin
            st_d = ST_ONE;
          end
        end
        ST_TWO: begin
          // upstream is blocked here, so only a downstream take can move the queue
          if (out_fire_s) begin
            st_d        = ST_ONE;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            in_ready_d  = 1'b1;
          end else begin
            in_ready_d = 1'b0;
          end
        end
        default: begin
          st_d        = ST_EMPTY;
          main_vld_d  = 1'b0;
          main_ctrl_d = {CTRL_W{1'b0}};
          in_ready_d  = 1'b1;
        end
      endcase
    end
  end

  // stage state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q        <= ST_EMPTY;
      main_vld_q  <= 1'b0;
      main_ctrl_q <= {CTRL_W{1'b0}};
      main_data_q <= {DATA_W{1'b0}};
      skid_ctrl_q <= {CTRL_W{1'b0}};
      skid_data_q <= {DATA_W{1'b0}};
      in_ready_q  <= 1'b1;
    end else begin
      st_q        <= st_d;
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_vld_q;
  assign bus.out_ctrl  = main_ctrl_q;
  assign bus.out_data  = main_data_q;

`ifdef PIPE_REG_STATS_EN
  pipe_reg_stats #(.STAT_W(STAT_W)) u_stats (
    .clk          (clk),
    .rst          (rst),
    .stall_inc_i  (main_vld_q & ~bus.out_ready),
    .bubble_inc_i (~main_vld_q),
    .stall_cnt_o  (stall_cnt),
    .bubble_cnt_o (bubble_cnt)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed, table-driven bench for pipe_stage_reg; counter checks build only with PIPE_REG_STATS_EN.
module tb_pipe_stage_reg;
  import mips_pipe_pkg::*;

  localparam int unsigned CW = EXMEM_CTRL_W;
  localparam int unsigned DW = EXMEM_DATA_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_stage_reg_if #(.CTRL_W(CW), .DATA_W(DW)) bus ();

`ifdef PIPE_REG_STATS_EN
  logic [15:0] stall_cnt, bubble_cnt;
  logic        sat_inc = 1'b0;
  logic [1:0]  sat_stall, sat_bubble;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .STAT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_reg_stats #(.STAT_W(2)) u_sat (
    .clk(clk), .rst(rst), .stall_inc_i(sat_inc), .bubble_inc_i(1'b0),
    .stall_cnt_o(sat_stall), .bubble_cnt_o(sat_bubble)
  );
`else
  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus.slave)
  );
`endif

  typedef struct {
    logic          iv;
    logic [CW-1:0] ic;
    logic [DW-1:0] id;
    logic          ordy;
    logic          fl;
    logic          eov;
    logic [CW-1:0] eoc;
    logic [DW-1:0] eod;
    logic          eir;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic ov, input logic [CW-1:0] oc,
                            input logic [DW-1:0] od, input logic ir);
    check({tag, ".out_valid"}, {127'd0, bus.out_valid}, {127'd0, ov});
    check({tag, ".out_ctrl"},  {123'd0, bus.out_ctrl},  {123'd0, oc});
    check({tag, ".out_data"},  {26'd0, bus.out_data},   {26'd0, od});
    check({tag, ".in_ready"},  {127'd0, bus.in_ready},  {127'd0, ir});
  endtask

  function automatic vec_t mk(input logic iv, input logic [CW-1:0] ic, input logic [7:0] id,
                              input logic ordy, input logic fl, input logic eov,
                              input logic [CW-1:0] eoc, input logic [7:0] eod, input logic eir);
    vec_t v;
    v.iv = iv; v.ic = ic; v.id = {94'd0, id}; v.ordy = ordy; v.fl = fl;
    v.eov = eov; v.eoc = eoc; v.eod = {94'd0, eod}; v.eir = eir;
    return v;
  endfunction

  task automatic drive(input logic iv, input logic [CW-1:0] ic, input logic [7:0] id, input logic ordy);
    bus.in_valid  = iv;
    bus.in_ctrl   = ic;
    bus.in_data   = {94'd0, id};
    bus.out_ready = ordy;
  endtask

  initial begin
    // each row: inputs before the edge, expected outputs just after it
    for (int d = 1; d <= 8; d++) begin
      vecs.push_back(mk(1'b1, 5'(d), 8'(d), 1'b1, 1'b0, 1'b1, 5'(d), 8'(d), 1'b1));
    end
    vecs.push_back(mk(1'b0, 5'd31, 8'hEE, 1'b1, 1'b0, 1'b0, 5'd0, 8'd8, 1'b1));
    // backpressure: 3 accepted, out_ready drops, 4 into skid, 5 held upstream
    vecs.push_back(mk(1'b1, 5'd3, 8'd3, 1'b1, 1'b0, 1'b1, 5'd3, 8'd3, 1'b1));
    vecs.push_back(mk(1'b1, 5'd4, 8'd4, 1'b0, 1'b0, 1'b1, 5'd3, 8'd3, 1'b0));
    vecs.push_back(mk(1'b1, 5'd5, 8'd5, 1'b0, 1'b0, 1'b1, 5'd3, 8'd3, 1'b0));
    vecs.push_back(mk(1'b1, 5'd5, 8'd5, 1'b1, 1'b0, 1'b1, 5'd4, 8'd4, 1'b1));
    vecs.push_back(mk(1'b1, 5'd5, 8'd5, 1'b1, 1'b0, 1'b1, 5'd5, 8'd5, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0, 5'd0, 8'd5, 1'b1));
    // flush in TWO with 0x2A offered, then flush racing an accept
    vecs.push_back(mk(1'b1, 5'd6, 8'd6, 1'b0, 1'b0, 1'b1, 5'd6, 8'd6, 1'b1));
    vecs.push_back(mk(1'b1, 5'd7, 8'd7, 1'b0, 1'b0, 1'b1, 5'd6, 8'd6, 1'b0));
    vecs.push_back(mk(1'b1, 5'd31, 8'h2A, 1'b0, 1'b1, 1'b0, 5'd0, 8'd6, 1'b1));
    vecs.push_back(mk(1'b0, 5'd31, 8'h2A, 1'b1, 1'b0, 1'b0, 5'd0, 8'd6, 1'b1));
    vecs.push_back(mk(1'b1, 5'd31, 8'h2A, 1'b1, 1'b1, 1'b0, 5'd0, 8'd6, 1'b1));
    vecs.push_back(mk(1'b1, 5'd9, 8'd9, 1'b1, 1'b0, 1'b1, 5'd9, 8'd9, 1'b1));
    // bubble after ctrl 01010: control zeroed, payload retained
    vecs.push_back(mk(1'b1, 5'b01010, 8'h55, 1'b1, 1'b0, 1'b1, 5'b01010, 8'h55, 1'b1));
    vecs.push_back(mk(1'b0, 5'b11111, 8'h99, 1'b1, 1'b0, 1'b0, 5'd0, 8'h55, 1'b1));
    vecs.push_back(mk(1'b0, 5'b11111, 8'h99, 1'b0, 1'b0, 1'b0, 5'd0, 8'h55, 1'b1));
    vecs.push_back(mk(1'b0, 5'b11111, 8'h99, 1'b1, 1'b0, 1'b0, 5'd0, 8'h55, 1'b1));
    // ONE with neither side firing holds
    vecs.push_back(mk(1'b1, 5'd17, 8'h11, 1'b0, 1'b0, 1'b1, 5'd17, 8'h11, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b1, 5'd17, 8'h11, 1'b1));
    vecs.push_back(mk(1'b0, 5'd0, 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 8'h11, 1'b1));

    // reset held with a valid beat offered
    drive(1'b1, 5'b11111, 8'h7F, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check_outs("reset", 1'b0, 5'd0, {DW{1'b0}}, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, vecs[i].ic, vecs[i].id[7:0], vecs[i].ordy);
      flush = vecs[i].fl;
      @(posedge clk);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].eov, vecs[i].eoc, vecs[i].eod, vecs[i].eir);
      @(negedge clk);
    end
    flush = 1'b0;

    // asynchronous reset while both slots are full
    drive(1'b1, 5'd1, 8'h70, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 5'd2, 8'h71, 1'b0);
    @(posedge clk);
    #1;
    check("two_before_rst.in_ready", {127'd0, bus.in_ready}, 128'd0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_outs("midrst", 1'b0, 5'd0, {DW{1'b0}}, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd12, 8'h3C, 1'b1);
    #1;
    check("post_rst_empty.out_valid", {127'd0, bus.out_valid}, 128'd0);
    @(posedge clk);
    #1;
    check_outs("post_rst_first", 1'b1, 5'd12, {94'd0, 8'h3C}, 1'b1);
    @(negedge clk);
    drive(1'b0, 5'd0, 8'h00, 1'b1);
    @(posedge clk);
    #1;
    check_outs("post_rst_drain", 1'b0, 5'd0, {94'd0, 8'h3C}, 1'b1);

`ifdef PIPE_REG_STATS_EN
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 5'd1, 8'h01, 1'b0);
    @(posedge clk);                // empty before this edge: bubble 1
    @(negedge clk);
    drive(1'b0, 5'd0, 8'h00, 1'b0);
    repeat (4) @(posedge clk);     // four stalled cycles
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);                // delivered, not a stall
    repeat (2) @(posedge clk);     // two idle cycles: bubble 3
    #1;
    check("stall_cnt", {112'd0, stall_cnt}, 128'd4);
    check("bubble_cnt", {112'd0, bubble_cnt}, 128'd3);
    @(negedge clk);
    sat_inc = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("stall_sat", {126'd0, sat_stall}, 128'd3);
    check("bubble_sat_idle", {126'd0, sat_bubble}, 128'd0);
    sat_inc = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
